lab2_mem_ctrl: RTL

LAB2_MEM_CTRL -- requirements
Module: lab2_mem_ctrl

---
 rtl/lab2_pkg.sv | 13 +
 rtl/lab2_spram.sv | 23 ++
 rtl/lab2_mem_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lab2_pkg.sv
// Shared types and default sizing for the lab2 memory controller.
package lab2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int LAB2_WIDTH = 8;
  localparam int LAB2_DEPTH = 16;

endpackage

// File: rtl/lab2_spram.sv
// Single-port RAM: synchronous write, registered read-first output.
module lab2_spram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lab2_mem_ctrl.sv
// Capture/append/playback controller around a small single-port memory.
// Optional LAB2_AUTO_PLAY_EN: timed rd_ptr advance every STEP_CYCLES while showing.
module lab2_mem_ctrl
  import lab2_pkg::*;
#(
  parameter int WIDTH       = LAB2_WIDTH,
  parameter int DEPTH       = LAB2_DEPTH,
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     save_data,
  input  logic                     write_en,
  input  logic                     show_reg,
  input  logic [WIDTH-1:0]         d_in,
  output logic [WIDTH-1:0]         d_out,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic                     full,
  output logic                     empty,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] rd_data;
  logic             mem_we;
  logic             do_save, do_write, do_show;
  logic             show_adv, show_last, auto_tick;

  // Fixed priority save > write > show; everything is dropped while writing.
  assign do_save   = save_data && (state_reg != ST_WRITE);
  assign do_write  = !save_data && write_en;
  assign do_show   = !save_data && !write_en && show_reg;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign show_last = ({1'b0, rd_ptr_reg} == (count_reg - 1'b1));
  assign show_adv  = (state_reg == ST_SHOW) && !do_write && (do_show || auto_tick);

`ifdef LAB2_AUTO_PLAY_EN
  logic [31:0] step_cnt_reg;

  assign auto_tick = (state_reg == ST_SHOW) && (step_cnt_reg == 32'(STEP_CYCLES - 1));

  // Held at zero outside SHOW, so every SHOW entry starts a full interval.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt_reg <= '0;
    end else if ((state_reg != ST_SHOW) || show_adv) begin
      step_cnt_reg <= '0;
    end else begin
      step_cnt_reg <= step_cnt_reg + 1'b1;
    end
  end
`else
  // The interval has no meaning without the playback counter.
  assign auto_tick = 1'b0 && (STEP_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (do_write && !full) begin
          state_next = ST_WRITE;
        end else if (do_show && !empty) begin
          state_next = ST_SHOW;
        end
      end
      ST_WRITE: state_next = ST_IDLE;
      ST_SHOW: begin
        if (do_write) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg == ST_WRITE);
    mem_we   = (state_reg == ST_WRITE);
    mem_addr = (state_reg == ST_SHOW) ? rd_ptr_reg : wr_ptr_reg;
    d_out    = (state_reg == ST_SHOW) ? rd_data : hold_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_save) begin
        hold_reg <= d_in;
      end
      if (state_reg == ST_WRITE) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (!full) begin
          count_reg <= count_reg + 1'b1;
        end
      end
      if ((state_reg == ST_IDLE) && (state_next == ST_SHOW)) begin
        rd_ptr_reg <= '0;
      end else if (show_adv) begin
        rd_ptr_reg <= show_last ? '0 : rd_ptr_reg + 1'b1;
      end
    end
  end

  lab2_spram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_spram (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(hold_reg),
    .rdata(rd_data)
  );

endmodule
